// File: rtl/ram_program_loader_pkg.sv
// Shared definitions for the RAM program loader: FSM state encoding.
package ram_program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/ram_program_loader_if.sv
// Host stream, control/status and RAM write-port signals of the program loader.
interface ram_program_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  iStart;
    logic [ADDR_WIDTH-1:0] iStartAddress;
    logic [ADDR_WIDTH-1:0] iLength;
    logic                  iValid;
    logic [DATA_WIDTH-1:0] iData;
    logic                  oReady;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0] oWriteData;
    logic                  oBusy;
    logic                  oDone;
    logic                  oError;
    logic                  oCpuReset;

    modport master (
        output iStart, iStartAddress, iLength, iValid, iData,
        input  oReady, oWriteEnable, oWriteAddress, oWriteData,
               oBusy, oDone, oError, oCpuReset
    );

    modport slave (
        input  iStart, iStartAddress, iLength, iValid, iData,
        output oReady, oWriteEnable, oWriteAddress, oWriteData,
               oBusy, oDone, oError, oCpuReset
    );
endinterface

// File: rtl/ram_program_loader_upcounter.sv
// Loadable up-counter: Reset loads Initial, Enable increments with natural wrap.
module UPCOUNTER_POSEDGE #(
    parameter int WIDTH = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Initial,
    input  logic             Enable,
    output logic [WIDTH-1:0] Counter
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Counter <= Initial;
        end else if (Enable) begin
            Counter <= Counter + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_program_loader.sv
// Streams words into consecutive RAM addresses, verifies a trailing additive
// checksum and releases the core from reset only after a clean load.
module ram_program_loader
    import ram_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 10
) (
    input logic                 Clock,
    input logic                 Reset,
    ram_program_loader_if.slave bus
);

    localparam logic [31:0] MEM_LAST = 32'(MEM_SIZE);

    loader_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_ready;
    logic                  r_write_enable;
    logic [ADDR_WIDTH-1:0] r_write_address;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_cpu_reset;

    logic                  w_idle_like;
    logic                  w_start;
    logic                  w_beat;
    logic                  w_in_range;
    logic                  w_write;
    logic                  w_cnt_load;
    logic [ADDR_WIDTH-1:0] w_cnt_init;
    logic [ADDR_WIDTH-1:0] w_address;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_start     = bus.iStart && w_idle_like;
    // oReady is a register, so the beat never depends combinationally on iValid -> oReady
    assign w_beat      = bus.iValid && r_ready;
    assign w_in_range  = 32'(w_address) <= MEM_LAST;
    assign w_write     = w_beat && (r_state == S_LOAD) && w_in_range;

    // Global reset clears the address to 0; a start loads the start address
    assign w_cnt_load  = Reset || w_start;
    assign w_cnt_init  = Reset ? '0 : bus.iStartAddress;

    UPCOUNTER_POSEDGE #(
        .WIDTH (ADDR_WIDTH)
    ) u_address (
        .Clock   (Clock),
        .Reset   (w_cnt_load),
        .Initial (w_cnt_init),
        .Enable  (w_write),
        .Counter (w_address)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_sum           <= '0;
            r_ready         <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_cpu_reset     <= 1'b1;
        end else begin
            r_write_enable <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.iStart) begin
                        r_remaining <= bus.iLength;
                        r_sum       <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= (bus.iLength == '0) ? S_CHECK : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        if (w_in_range) begin
                            r_write_enable  <= 1'b1;
                            r_write_address <= w_address;
                            r_write_data    <= bus.iData;
                            r_remaining     <= r_remaining - ADDR_WIDTH'(1);
                            r_sum           <= r_sum + bus.iData;
                            if (r_remaining == ADDR_WIDTH'(1)) begin
                                r_state <= S_CHECK;
                            end
                        end else begin
                            // Out-of-range beat is swallowed without touching RAM
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_beat) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        if (bus.iData == r_sum) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oReady        = r_ready;
    assign bus.oWriteEnable  = r_write_enable;
    assign bus.oWriteAddress = r_write_address;
    assign bus.oWriteData    = r_write_data;
    assign bus.oBusy         = r_busy;
    assign bus.oDone         = r_done;
    assign bus.oError        = r_error;
    assign bus.oCpuReset     = r_cpu_reset;

endmodule

// File: doc/ram_program_loader.md
# ram_program_loader

Write-side front end for the single-read-port program/data RAM: accepts a word stream over a valid/ready handshake, writes each word into consecutive RAM addresses through the RAM write port, and verifies a trailing checksum. It holds the processor core in reset (oCpuReset) until a load completes with a good checksum. It sits between the host/debug link and the RAM write port. The core owns the RAM read port.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; matches RAM data width
- ADDR_WIDTH, 10, RAM address width
- MEM_SIZE, 10, highest valid RAM index (RAM holds MEM_SIZE+1 words)

Ports:
- Clock  in  1  clock; all logic on posedge
- Reset  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle pulse; starts a load when idle, done or errored
- iStartAddress  in  ADDR_WIDTH  first RAM address; sampled on accepted iStart
- iLength  in  ADDR_WIDTH  number of data words; sampled on accepted iStart
- iValid  in  1  stream word valid
- iData  in  DATA_WIDTH  stream word (data words, then one checksum word)
- oReady  out  1  loader accepts iData this cycle
- oWriteEnable  out  1  to RAM iWriteEnable
- oWriteAddress  out  ADDR_WIDTH  to RAM iWriteAddress
- oWriteData  out  DATA_WIDTH  to RAM iDataIn
- oBusy  out  1  load in progress (LOAD or CHECK)
- oDone  out  1  load finished, checksum matched
- oError  out  1  address overflow or checksum mismatch
- oCpuReset  out  1  holds the core in reset

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERROR. All outputs are registered.
- Beat: iValid && oReady at a posedge. oReady = 1 in LOAD and CHECK only.
- IDLE, DONE or ERROR + iStart:
  - latch address = iStartAddress, remaining = iLength; clear sum; clear oDone/oError; assert oCpuReset.
  - Go to LOAD, or to CHECK if iLength == 0.
- iStart in LOAD or CHECK is ignored.
- LOAD beat, address <= MEM_SIZE:
  - write iData at address; address += 1; remaining -= 1.
  - sum = (sum + iData) mod 2^DATA_WIDTH.
  - When remaining reaches 0, go to CHECK.
- LOAD beat, address > MEM_SIZE:
  - the beat is consumed and no write is issued; go to ERROR.
  - Address arithmetic is ADDR_WIDTH-bit with wrap. The bound check runs before any write, so a wrapped address never writes.
- CHECK beat:
  - iData == sum: go to DONE, oDone = 1, oCpuReset = 0.
  - otherwise: go to ERROR, oError = 1, oCpuReset stays 1.
  - No RAM write is issued in CHECK.
- DONE and ERROR hold until iStart or Reset.
- Reset values: state IDLE, oReady 0, oWriteEnable 0, oWriteAddress 0, oWriteData 0, oBusy 0, oDone 0, oError 0, oCpuReset 1. Internal sum, address and remaining are all 0.
- Reset mid-load: abort immediately to the reset values. Partially written RAM contents are left as is. The core stays in reset.

## Timing
- A beat at edge N drives oWriteEnable = 1 with its address and data during cycle N+1. The RAM commits the word at edge N+1.
- oWriteEnable is high exactly one cycle per accepted LOAD beat. Back-to-back beats give a continuous write burst at 1 word/cycle.
- The state and oReady update at the same edge as the beat. After the last data beat, oReady stays 1 because CHECK also accepts.
- oDone/oError rise, and oCpuReset falls, the cycle after the checksum beat.
- iStart is accepted at edge N: oBusy = 1 and oReady = 1 from cycle N+1.
- No combinational path from iValid to oReady.

## Structure
- Shared package: state encoding constants (IDLE=0, LOAD=1, CHECK=2, DONE=3, ERROR=4, 3-bit).
- Natural sub-module: UPCOUNTER_POSEDGE for the write address, with Initial = iStartAddress, Reset = start, Enable = accepted LOAD beat.
- Remaining-count, sum and FSM stay inline.

## Test plan
- Good load: start addr 2, len 3, words 0x11, 0x22, 0x33, checksum 0x66.
  - writes 2←0x11, 3←0x22, 4←0x33 on consecutive cycles; then oDone = 1, oCpuReset = 0, oError = 0.
- Bad checksum: same stream with checksum 0x67.
  - three writes occur; oError = 1, oDone = 0, oCpuReset stays 1.
- Overflow: start addr 9, len 3, MEM_SIZE 10.
  - writes at 9 and 10 only; the third beat is consumed with no write; oError = 1.
- Zero length: iLength 0, checksum word 0x00.
  - no writes; oDone = 1. With checksum 0x01: oError = 1.
- Throttled stream:
  - iValid toggles 1/0 with iStart pulsed mid-load: the pulse is ignored.
  - oWriteEnable pulses only after each beat, and addresses stay contiguous.
- Reset mid-load: Reset asserted after 2 of 4 beats.
  - next cycle all outputs are at reset values (oCpuReset 1).
  - a subsequent full load completes normally.
